// File: rtl/ad9361_spi_slave.sv
// AD9361-style 24-bit SPI register slave: oversampled SPI front end, 1024x8
// register file, product ID and calibration-status emulation.
module ad9361_spi_slave #(
    parameter int unsigned CAL_DELAY  = 1000,
    parameter logic [7:0]  PRODUCT_ID = 8'h0A
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic       frame_abort
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = (CAL_DELAY > 0) ? $clog2(CAL_DELAY + 1) : 1;

    localparam logic [4:0] LAST_INSTR_BIT = 5'd15;
    localparam logic [4:0] LAST_BIT       = 5'd23;
    localparam logic [4:0] BIT_SAT        = 5'd24;

    localparam logic [ADDR_W-1:0] ADDR_CAL  = 10'h016;
    localparam logic [ADDR_W-1:0] ADDR_PID  = 10'h037;
    localparam logic [7:0]        CAL_KEEP  = 8'h2C;

    typedef enum logic [1:0] {IDLE, INSTR, DATA, WAIT_CS} state_t;

    // synchronizers; CS chain resets low so a CS held low across reset is not a new frame
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;

    state_t            state_q;
    logic [4:0]        bit_cnt_q;
    logic [14:0]       shift_q;
    logic              is_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_q;
    logic              spi_miso_q, spi_miso_oe_q;
    logic              wr_en_q, rd_en_q, frame_abort_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic [7:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [7:0]        cal_reg_q;
    logic [CNT_W-1:0]  cal_cnt_q;
    logic              cal_run_q;
    logic [CNT_W-1:0]  ready_cnt_q;
    logic              cal_ready_q;

    logic              sclk_rise, sclk_fall, cs_fall;
    logic [ADDR_W-1:0] instr_addr_d;
    logic [7:0]        data_d;
    logic [7:0]        rd_base_d;
    logic [7:0]        rd_val_d;
    logic              write_hit, mem_we;

    assign sclk_rise    = sclk_s2_q & ~sclk_prev_q;
    assign sclk_fall    = ~sclk_s2_q & sclk_prev_q;
    assign cs_fall      = cs_prev_q & ~cs_s2_q;
    assign instr_addr_d = {shift_q[8:0], mosi_s2_q};
    assign data_d       = {shift_q[6:0], mosi_s2_q};
    assign write_hit    = (state_q == DATA) && !cs_s2_q && sclk_rise &&
                          (bit_cnt_q == LAST_BIT) && is_wr_q;
    assign mem_we       = write_hit && (addr_q != ADDR_CAL) && (addr_q != ADDR_PID);

    assign spi_miso    = spi_miso_q;
    assign spi_miso_oe = spi_miso_oe_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_en       = rd_en_q;
    assign frame_abort = frame_abort_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_prev_q   <= 1'b0;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
        end else begin
            cs_s1_q     <= spi_cs;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            sclk_s1_q   <= spi_sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= spi_mosi;
            mosi_s2_q   <= mosi_s1_q;
        end
    end

    // register read mux with product ID and calibration-status overlays
    always_comb begin
        rd_base_d = valid_q[instr_addr_d] ? mem_q[instr_addr_d] : 8'h00;
        rd_val_d  = rd_base_d;
        case (instr_addr_d)
            ADDR_PID: rd_val_d = PRODUCT_ID;
            ADDR_CAL: rd_val_d = cal_reg_q;
            10'h05E, 10'h244, 10'h284: rd_val_d = rd_base_d | {cal_ready_q, 7'b0};
            10'h247, 10'h287:          rd_val_d = rd_base_d | {6'b0, cal_ready_q, 1'b0};
            default: rd_val_d = rd_base_d;
        endcase
    end

    // frame FSM and MISO shifter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            is_wr_q       <= 1'b0;
            addr_q        <= '0;
            tx_q          <= '0;
            spi_miso_q    <= 1'b0;
            spi_miso_oe_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_en_q       <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            frame_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (cs_fall) begin
                        state_q <= INSTR;
                    end
                end
                INSTR, DATA: begin
                    if (cs_s2_q) begin
                        state_q       <= IDLE;
                        frame_abort_q <= 1'b1;
                        bit_cnt_q     <= '0;
                    end else if (sclk_rise) begin
                        shift_q <= {shift_q[13:0], mosi_s2_q};
                        if (bit_cnt_q < BIT_SAT) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                        if (state_q == INSTR && bit_cnt_q == LAST_INSTR_BIT) begin
                            state_q <= DATA;
                            is_wr_q <= shift_q[14];
                            addr_q  <= instr_addr_d;
                            if (!shift_q[14]) begin
                                rd_en_q       <= 1'b1;
                                tx_q          <= rd_val_d;
                                spi_miso_oe_q <= 1'b1;
                            end
                        end else if (state_q == DATA && bit_cnt_q == LAST_BIT) begin
                            state_q <= WAIT_CS;
                            if (is_wr_q) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                wr_data_q <= data_d;
                            end
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_s2_q) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise && bit_cnt_q < BIT_SAT) begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (cs_s2_q) begin
                spi_miso_oe_q <= 1'b0;
                spi_miso_q    <= 1'b0;
            end else if (spi_miso_oe_q && sclk_fall) begin
                spi_miso_q <= tx_q[7];
                tx_q       <= {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= data_d;
        end
    end

    // written-location tracking and calibration timers; a 0x016 write beats expiry
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_q     <= '0;
            cal_reg_q   <= 8'h00;
            cal_cnt_q   <= '0;
            cal_run_q   <= 1'b0;
            ready_cnt_q <= '0;
            cal_ready_q <= 1'b0;
        end else begin
            if (mem_we) begin
                valid_q[addr_q] <= 1'b1;
            end
            if (write_hit && addr_q == ADDR_CAL) begin
                cal_reg_q <= data_d;
                cal_cnt_q <= '0;
                cal_run_q <= 1'b1;
            end else if (cal_run_q) begin
                if (cal_cnt_q == CNT_W'(CAL_DELAY)) begin
                    cal_reg_q <= cal_reg_q & CAL_KEEP;
                    cal_run_q <= 1'b0;
                end else begin
                    cal_cnt_q <= cal_cnt_q + CNT_W'(1);
                end
            end
            if (!cal_ready_q) begin
                if (32'(ready_cnt_q) + 32'd1 >= CAL_DELAY) begin
                    cal_ready_q <= 1'b1;
                end else begin
                    ready_cnt_q <= ready_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ad9361_spi_slave.sv
// Directed + randomized bench for ad9361_spi_slave against a register-map model.
module tb_ad9361_spi_slave;

    localparam int unsigned CAL   = 1000;
    localparam logic [7:0]  PID   = 8'h0A;
    localparam int          H     = 8;
    localparam int          FETCH = 32 * H + 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst, spi_cs, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe, wr_en, rd_en, frame_abort;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, ab_cnt = 0, wr_cyc = 0;
    logic [9:0] last_wa;
    logic [7:0] last_wd;

    // reference register map
    logic [7:0] m_mem [1024];
    bit         m_val [1024];
    logic [7:0] cal_v;
    bit         cal_written;
    int         cal_t, rst_t, start_cyc;

    ad9361_spi_slave #(.CAL_DELAY(CAL), .PRODUCT_ID(PID)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
        .frame_abort(frame_abort)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
            wr_cyc  <= cyc;
        end
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (frame_abort) ab_cnt <= ab_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [7:0] model_read(input logic [9:0] a, input int t);
        logic [7:0] v;
        bit ready;
        v = m_val[a] ? m_mem[a] : 8'h00;
        ready = (t - rst_t) >= int'(CAL);
        case (a)
            10'h037: v = PID;
            10'h016: begin
                v = cal_v;
                if (cal_written && (t - cal_t) >= int'(CAL)) begin
                    v[7] = 1'b0; v[6] = 1'b0; v[4] = 1'b0; v[1] = 1'b0; v[0] = 1'b0;
                end
            end
            10'h05E, 10'h244, 10'h284: if (ready) v[7] = 1'b1;
            10'h247, 10'h287:          if (ready) v[1] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // one SPI frame as a mode-0 master; optional reset pulse before bit index rst_at
    task automatic frame(input logic wr, input logic [9:0] addr, input logic [7:0] din,
                         input int nbits, input int rst_at, output logic [7:0] dout,
                         output logic oe15, output logic oe_end, output logic oe_rst,
                         output int ev_after);
        logic [23:0] w;
        int snap;
        w = {wr, 3'($urandom_range(0, 7)), 2'b00, addr, din};
        dout = 8'h00; oe15 = 1'b0; oe_rst = 1'b0; ev_after = 0; snap = 0;
        @(negedge sys_clk);
        start_cyc = cyc;
        spi_cs = 1'b0;
        wait_cyc(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                sys_rst = 1'b1;
                #1 oe_rst = spi_miso_oe;
                wait_cyc(3);
                sys_rst = 1'b0;
                rst_t = cyc;
                cal_v = 8'h00;
                cal_written = 1'b0;
                wait_cyc(1);
                snap = wr_cnt + rd_cnt + ab_cnt;
            end
            spi_mosi = w[23-i];
            wait_cyc(H);
            if (i == 15) oe15 = spi_miso_oe;
            if (i >= 16) dout[23-i] = spi_miso;
            spi_sclk = 1'b1;
            wait_cyc(H);
            spi_sclk = 1'b0;
        end
        wait_cyc(H);
        oe_end = spi_miso_oe;
        spi_cs = 1'b1;
        wait_cyc(2 * H);
        if (rst_at >= 0) ev_after = wr_cnt + rd_cnt + ab_cnt - snap;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        logic [7:0] dout;
        logic oe15, oe_end, oe_rst;
        int ev, w0;
        w0 = wr_cnt;
        frame(1'b1, a, d, 24, -1, dout, oe15, oe_end, oe_rst, ev);
        check($sformatf("wr_pulse_%03h", a), 32'(wr_cnt - w0), 32'd1);
        check($sformatf("wr_oe_%03h", a), 32'(oe_end), 32'd0);
        if (a == 10'h016) begin
            cal_v = d; cal_written = 1'b1; cal_t = cyc;
        end else if (a != 10'h037) begin
            m_mem[a] = d; m_val[a] = 1'b1;
        end
    endtask

    task automatic do_read(input logic [9:0] a, output logic oe15, output logic oe_end);
        logic [7:0] dout, exp;
        logic oe_rst;
        int ev, r0;
        exp = model_read(a, cyc + 1 + FETCH);
        r0 = rd_cnt;
        frame(1'b0, a, 8'($urandom), 24, -1, dout, oe15, oe_end, oe_rst, ev);
        check($sformatf("rd_%03h", a), 32'(dout), 32'(exp));
        check($sformatf("rd_pulse_%03h", a), 32'(rd_cnt - r0), 32'd1);
    endtask

    initial begin
        logic [9:0] a;
        logic [9:0] pool [8];
        logic [7:0] dout;
        logic oe15, oe_end, oe_rst;
        int ev, w0, a0, len, target;

        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 8'h00; m_val[i] = 1'b0;
        end
        cal_v = 8'h00; cal_written = 1'b0; cal_t = 0;
        sys_rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        wait_cyc(5);
        sys_rst = 1'b0;
        rst_t = cyc;
        wait_cyc(1);

        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);

        // calibration-ready status before and after CAL cycles
        wait_cyc(8);
        do_read(10'h05E, oe15, oe_end);
        while (cyc < rst_t + int'(CAL) + 10) wait_cyc(1);
        do_read(10'h05E, oe15, oe_end);

        // basic write then read-back
        do_write(10'h2A5, 8'h3C);
        check("wr_addr_2a5", 32'(last_wa), 32'h2A5);
        check("wr_data_2a5", 32'(last_wd), 32'h3C);
        do_read(10'h2A5, oe15, oe_end);

        // 0x016 calibration done-bit clearing and restart at expiry
        do_write(10'h016, 8'h13);
        do_read(10'h016, oe15, oe_end);
        while (cyc < cal_t + int'(CAL) + 20) wait_cyc(1);
        do_read(10'h016, oe15, oe_end);
        do_write(10'h016, 8'h13);
        len = wr_cyc - start_cyc;
        target = wr_cyc + int'(CAL) - len;
        for (int k = 0; k < 3000 && cyc < target; k++) wait_cyc(1);
        do_write(10'h016, 8'h13);
        do_read(10'h016, oe15, oe_end);

        // product ID ignores writes; MISO enable window
        do_write(10'h037, 8'hFF);
        do_read(10'h037, oe15, oe_end);
        check("pid_oe_before16", 32'(oe15), 32'd0);
        check("pid_oe_after16", 32'(oe_end), 32'd1);
        check("pid_oe_after_cs", 32'(spi_miso_oe), 32'd0);
        check("pid_miso_after_cs", 32'(spi_miso), 32'd0);

        // CS raised mid-frame aborts the write
        w0 = wr_cnt; a0 = ab_cnt;
        frame(1'b1, 10'h100, 8'h77, 20, -1, dout, oe15, oe_end, oe_rst, ev);
        check("abort_pulse", 32'(ab_cnt - a0), 32'd1);
        check("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
        do_read(10'h100, oe15, oe_end);
        do_write(10'h100, 8'h5A);
        do_read(10'h100, oe15, oe_end);

        // randomized traffic against the model
        pool[0] = 10'h05E; pool[1] = 10'h244; pool[2] = 10'h287; pool[3] = 10'h037;
        for (int i = 4; i < 8; i++) pool[i] = 10'($urandom_range(64, 1023));
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(0, 1023));
            else a = pool[$urandom_range(0, 7)];
            if (a == 10'h016) a = 10'h017;
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else do_read(a, oe15, oe_end);
        end

        // reset in the middle of a read; CS stays low across reset
        frame(1'b0, 10'h2A5, 8'h00, 24, 18, dout, oe15, oe_end, oe_rst, ev);
        check("rst_mid_oe", 32'(oe_rst), 32'd0);
        check("rst_mid_no_events", 32'(ev), 32'd0);
        check("rst_mid_oe_end", 32'(oe_end), 32'd0);
        do_read(10'h037, oe15, oe_end);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9361_spi_slave.md
AD9361_SPI_SLAVE -- requirements
Module: ad9361_spi_slave

Interface
REQ-001 SHALL have parameter CAL_DELAY, default 1000, meaning sys_clk cycles from reset or 0x016 write until calibration bits read as done.
REQ-002 SHALL have parameter PRODUCT_ID, default 8'h0A, meaning the fixed read value of register 0x037.
REQ-003 SHALL have ports, clock and reset first: sys_clk in 1, the single clock; sys_rst in 1, asynchronous active-high reset; spi_cs in 1, active-low chip select; spi_sclk in 1, SPI clock, idle low; spi_mosi in 1, serial data from the master; spi_miso out 1, serial data to the master; spi_miso_oe out 1, MISO drive enable.
REQ-004 SHALL have monitor ports: wr_en out 1, one-cycle register-write pulse; wr_addr out 10, address written; wr_data out 8, data written; rd_en out 1, one-cycle register-read pulse; frame_abort out 1, one-cycle pulse when CS deasserts mid-frame.

Function
REQ-005 SHALL pass spi_cs, spi_sclk and spi_mosi through 2-flop synchronizers before edge detection; the design is valid for sys_clk >= 8x SCLK.
REQ-006 SHALL take a frame as CS falling, then 24 SCLK bits MSB first: bit23 W/Rn (1 = write), bits22:20 byte count, bits19:18 ignored, bits17:8 address, bits7:0 data.
REQ-007 SHALL sample MOSI on the synchronized SCLK rising edge and update MISO on the synchronized SCLK falling edge.
REQ-008 SHALL implement states IDLE, INSTR, DATA and WAIT_CS.
REQ-009 Transitions SHALL be: IDLE->INSTR on CS low; INSTR->DATA after the 16th rising edge; DATA->WAIT_CS after the 24th rising edge; WAIT_CS->IDLE on CS high.
REQ-010 CS high in INSTR or DATA SHALL return the FSM to IDLE, pulse frame_abort for 1 cycle, perform no register write, and clear the bit counter.
REQ-011 Byte count other than 000 SHALL be accepted; only the first data byte SHALL be processed; later bits SHALL be ignored in WAIT_CS.
REQ-012 A write SHALL update the 1024x8 register array 1 cycle after the 24th rising edge is detected, with wr_en, wr_addr and wr_data valid in that same cycle.
REQ-013 A read SHALL fetch the register on the cycle after the 16th rising edge is detected, pulse rd_en for 1 cycle, and assert spi_miso_oe.
REQ-014 A read SHALL drive data bit7 on the next SCLK falling edge and bits6..0 on the following falling edges.
REQ-015 A read SHALL deassert spi_miso_oe and drive spi_miso to 0 on CS high.
REQ-016 Register 0x037 SHALL always read PRODUCT_ID; writes to it SHALL be discarded but still pulse wr_en.
REQ-017 A write to 0x016 SHALL store the data and (re)start a cal counter at 0.
REQ-018 While that counter is below CAL_DELAY, 0x016 SHALL read its stored value; on reaching CAL_DELAY, bits 7,6,4,1,0 of the 0x016 storage SHALL be cleared in one cycle and the counter SHALL stop.
REQ-019 A write to 0x016 on the same cycle as counter expiry SHALL win: data stored, counter restarted.
REQ-020 Status bits 0x05E[7], 0x244[7], 0x284[7], 0x247[1] and 0x287[1] SHALL read as stored value OR cal_ready, where cal_ready goes high CAL_DELAY cycles after reset deassertion and stays high.
REQ-021 All other addresses SHALL read back the last written value; unwritten locations SHALL read 0x00.
REQ-022 The bit counter SHALL be 5 bits and SHALL saturate at 24 within a frame, never wrapping.

Reset
REQ-023 On sys_rst high, the design SHALL enter IDLE and set spi_miso=0, spi_miso_oe=0, wr_en=0, rd_en=0, frame_abort=0, wr_addr=0, wr_data=0, cal counter stopped, cal_ready=0, bit counter 0 and the 0x016 storage to 0x00; other array contents need not be cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame without a write and without a frame_abort pulse; the next frame SHALL start only on a fresh CS falling edge.

Verification
REQ-025 Write 0x2A5=0x3C, then read 0x2A5 -> wr_en pulse with wr_addr=0x2A5, wr_data=0x3C; MISO shifts 0x3C; rd_en pulses once.
REQ-026 Read 0x037 after writing 0xFF to it -> MISO returns 0x0A; spi_miso_oe high only from the 16th bit until CS high.
REQ-027 Read 0x05E at reset+10 cycles and at reset+CAL_DELAY+10 cycles -> returns 0x00, then 0x80.
REQ-028 Write 0x016=0x13, read at once, then read after CAL_DELAY cycles -> returns 0x13, then 0x00; rewriting at the expiry cycle -> still 0x13.
REQ-029 CS raised after 20 bits of a write to 0x100 -> frame_abort pulses, no wr_en, 0x100 still reads 0x00; the next full frame works.
REQ-030 sys_rst asserted at bit 18 of a read -> spi_miso_oe=0 immediately, FSM in IDLE; a following read of 0x037 returns 0x0A.
